// File: rtl/data_memory.sv
// Block-granular backing memory behind the data cache: one line fill or
// write-back per access, fixed latency, busywait stalls the requester.
module data_memory #(
  parameter int ADDR_WIDTH  = 6,
  parameter int BLOCK_WIDTH = 128,
  parameter int LATENCY     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   read,
  input  logic                   write,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [BLOCK_WIDTH-1:0] writedata,
  output logic [BLOCK_WIDTH-1:0] readdata,
  output logic                   busywait
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
  logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;
  logic [BLOCK_WIDTH-1:0] mem_q [DEPTH];
  logic                   mem_we;
  logic                   valid_req;

  // Both read and write high is treated as no request at all.
  assign valid_req = read ^ write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_req) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
          wr_d    = write;
          addr_d  = address;
          wdata_d = writedata;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (wr_q) mem_we = 1'b1;
          else      rdata_d = mem_q[addr_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset clears the whole array, so an interrupted write-back leaves no trace.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Combinational in IDLE so the stall starts in the request cycle.
  assign busywait = !reset && ((state_q == IDLE && valid_req) || state_q == BUSY);
  assign readdata = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus queues expected responses,
// a monitor checks each access when busywait falls.
module tb_data_memory;
  localparam int AW  = 6;
  localparam int BW  = 128;
  localparam int LAT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [BW-1:0] writedata;
  logic [BW-1:0] readdata;
  logic          busywait;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit            rd;
    logic [BW-1:0] data;
  } exp_t;
  exp_t sb[$];

  localparam logic [BW-1:0] PAT  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [BW-1:0] ONES = {BW{1'b1}};
  localparam logic [BW-1:0] ONE  = 128'h1;
  localparam logic [BW-1:0] ZERO = '0;

  data_memory #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
  );

  always #5 clock = ~clock;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles and check the oldest expectation on each fall.
  bit prev_busy = 1'b0;
  int busy_cnt  = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_busy = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (busywait) begin
          busy_cnt++;
        end else if (prev_busy) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_access: busywait fell with no pending request");
          end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (busy_cnt != LAT + 1) begin
              failures++;
              $display("FAIL busy_len: got %0d cycles expected %0d", busy_cnt, LAT + 1);
            end
            if (e.rd) check_data("read_data", readdata, e.data);
          end
          busy_cnt = 0;
        end
        prev_busy = busywait;
      end
    end
  end

  // Called in cycle 0 (just after an edge); returns in the DONE cycle.
  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (busywait && n < 30);
    if (busywait) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: busywait still %0b after %0d cycles, expected 0", busywait, n);
    end
  endtask

  task automatic access(input bit rd, input logic [AW-1:0] a, input logic [BW-1:0] d,
                        input logic [BW-1:0] exp, input bit hold);
    exp_t e;
    e.rd = rd;
    e.data = exp;
    sb.push_back(e);
    read = rd; write = !rd; address = a; writedata = d;
    wait_done();
    if (!hold) begin
      read = 1'b0; write = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; read = 1'b1; write = 1'b0; address = 6'h2A; writedata = '0;
    #12;
    check1("reset_busywait", busywait, 1'b0);
    check_data("reset_readdata", readdata, ZERO);
    read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    access(1'b1, 6'h2A, ZERO, ZERO, 1'b0);
    access(1'b0, 6'h05, PAT, ZERO, 1'b0);
    access(1'b1, 6'h05, ZERO, PAT, 1'b0);

    access(1'b0, 6'd63, ONES, ZERO, 1'b0);
    access(1'b0, 6'd0, ONE, ZERO, 1'b0);
    access(1'b1, 6'd63, ZERO, ONES, 1'b0);
    access(1'b1, 6'd0, ZERO, ONE, 1'b0);
    access(1'b1, 6'h05, ZERO, PAT, 1'b0);

    // Request held through DONE: stall only resumes in the following IDLE cycle.
    access(1'b1, 6'd63, ZERO, ONES, 1'b1);
    check1("done_busywait", busywait, 1'b0);
    begin
      exp_t e;
      e.rd = 1'b1; e.data = ONES;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    check1("idle_rerequest_busywait", busywait, 1'b1);
    wait_done();
    read = 1'b0;
    @(posedge clock); #1;

    // Illegal read+write for 3 cycles.
    read = 1'b1; write = 1'b1; address = 6'h05; writedata = ZERO;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1("illegal_busywait", busywait, 1'b0);
      @(posedge clock); #1;
    end
    check_data("illegal_readdata_hold", readdata, ONES);
    read = 1'b0; write = 1'b0;
    @(posedge clock); #1;
    access(1'b1, 6'h05, ZERO, PAT, 1'b0);

    // Reset during the second BUSY cycle of a write to 0x10.
    write = 1'b1; address = 6'h10; writedata = ONES;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check1("busy_before_reset", busywait, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check1("reset_mid_busy_busywait", busywait, 1'b0);
    check_data("reset_mid_busy_readdata", readdata, ZERO);
    write = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    access(1'b1, 6'h10, ZERO, ZERO, 1'b0);
    access(1'b1, 6'h05, ZERO, ZERO, 1'b0);

    repeat (2) @(posedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_responses: got %0d outstanding expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Block-granular backing data memory directly downstream of the data cache: it services the cache's line fills and dirty-line write-backs. It stores 2^ADDR_WIDTH blocks of BLOCK_WIDTH bits and answers each request after a fixed multi-cycle latency. A busywait handshake stalls the cache controller for the whole access. A mandatory one-cycle release slot lets the controller drop its request before the next one is accepted.

## Interface
- ADDR_WIDTH, 6, block-address bits; depth = 2^ADDR_WIDTH blocks (64)
- BLOCK_WIDTH, 128, bits per block; equals one cache line
- LATENCY, 4, BUSY cycles per access; legal range 1..15
- clock  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-high
- read  input  1  block read request (line fill)
- write  input  1  block write request (write-back)
- address  input  ADDR_WIDTH  block address, i.e. the cache tag concatenated with the cache index
- writedata  input  BLOCK_WIDTH  block to store on write
- readdata  output  BLOCK_WIDTH  block returned by the last completed read
- busywait  output  1  high while a request is pending or in service

## Operation
- Storage: register array mem[0 .. 2^ADDR_WIDTH-1] of BLOCK_WIDTH bits.
- Valid request: exactly one of read and write is high. Both high is illegal and is ignored: no accept, busywait stays 0, no array or readdata change.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on a valid request at a rising edge, latch op, address and writedata. Load the counter with LATENCY-1 and go to BUSY.
  - BUSY: the counter decrements each edge. On the edge where the counter is 0, complete the access and go to DONE.
  - Read completion: readdata <= mem[latched address].
  - Write completion: mem[latched address] <= latched writedata. readdata is unchanged.
  - DONE: go to IDLE unconditionally on the next edge. read and write are ignored in DONE.
- busywait = (IDLE and valid request) or BUSY. It is combinational in IDLE, so it rises in the same cycle the request appears. It is 0 in DONE.
- Input changes after the accept edge have no effect on the access in flight.
- The counter is 4 bits wide. No wrap-around occurs because the counter reloads only in IDLE.
- readdata holds its value until the next read completion.
- Reset (asynchronous, at any time, including mid-BUSY):
  - state goes to IDLE and the counter to 0.
  - readdata goes to 0 and every mem entry to 0.
  - busywait is forced to 0 while reset is high.
  - An in-flight write is discarded.

## Timing
- Request asserted in cycle 0; accept at edge E1; completion at edge E(LATENCY+1).
- busywait is high in cycles 0..LATENCY, i.e. LATENCY+1 cycles.
- The falling edge of busywait coincides with readdata becoming valid. The cache may sample readdata on that falling edge.
- The requester must deassert read/write during the DONE cycle, in response to busywait low.
- The earliest next accept is the edge after DONE. Back-to-back accesses therefore occur every LATENCY+2 cycles.
- A write-back followed by a line fill to a different address is serviced as two independent accesses with no reordering.
- A read of an address returns the value of any earlier write to that address that reached completion.

## Test plan
- Reset: with reset high, busywait=0 and readdata=0. After release, a read of address 0x2A returns 128'h0 after LATENCY+1 busy cycles.
- Write 0x05 with 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, then read 0x05 → readdata equals that value at busywait fall. busywait is high for exactly 5 cycles per access with LATENCY=4.
- Address boundary: write address 63 with all-ones and address 0 with 128'h1. Reading each returns its own value and shows no aliasing.
- Request held high through DONE → no second access starts. busywait stays 0 in DONE and rises again only in the following IDLE cycle.
- read=write=1 for 3 cycles → busywait stays 0, and a subsequent read shows the array unchanged.
- Assert reset in the 2nd BUSY cycle of a write to 0x10 → busywait drops immediately. A later read of 0x10 returns 0.
